hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the IF/ID stage register and the PC. Drives enableIF/resetIF, the PC write

---
 rtl/mips_pkg.sv | 29 ++
 rtl/load_use_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode constants, hazard FSM states and helpers
//
// Contents:
//   OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_BNE/OP_J : 6-bit primary opcodes
//   hz_state_t                              : front-end hazard FSM state encoding
//   uses_rt()                               : 1 when the opcode reads rt as a source
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [1:0] {
        HZ_RUN       = 2'd0,
        HZ_LU_STALL  = 2'd1,
        HZ_FLUSH     = 2'd2,
        HZ_IMEM_WAIT = 2'd3
    } hz_state_t;

    // rt is a source for R-type ALU ops, both compare-branches and the store data.
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)   || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
//
// Ports:
//   id_opcode/id_rs/id_rt : instruction held in IF/ID
//   ex_memread/ex_rt      : load currently in EX and its destination
//   load_use              : IF/ID instruction needs the loaded value next cycle
module load_use_detect
    import mips_pkg::*;
(
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    // $0 is hardwired, so a load targeting it can never create a dependency.
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || ((ex_rt == id_rt) && uses_rt(id_opcode)));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - front-end hazard sequencer for PC and IF/ID register
//
// Parameters: FLUSH_CYCLES (1..7), IMEM_TIMEOUT (1..65535), CNT_W (perf counter width)
// Ports:
//   reloj, reset                    : clock, async active-high reset
//   id_opcode/id_rs/id_rt           : IF/ID instruction fields
//   ex_memread/ex_rt                : load in EX
//   branch_taken, id_jump           : control-flow redirects
//   imem_ready                      : instruction memory data valid
//   pc_enable/enableIF/resetIF      : PC write, IF/ID load, IF/ID squash
//   flush_idex                      : bubble into ID/EX
//   imem_err                        : sticky imem wait timeout
//   state_o                         : FSM state (debug)
//   stall_cnt/flush_cnt             : perf counters, only with HAZ_PERF_CNT_EN defined
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int IMEM_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       branch_taken,
    input  logic       id_jump,
    input  logic       imem_ready,
    output logic       pc_enable,
    output logic       enableIF,
    output logic       resetIF,
    output logic       flush_idex,
    output logic       imem_err,
    output logic [1:0] state_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_W  = 16'(IMEM_TIMEOUT);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
        $error("hazard_ctrl: FLUSH_CYCLES out of range");
    end
    if (IMEM_TIMEOUT < 1 || IMEM_TIMEOUT > 65535) begin : g_bad_timeout
        $error("hazard_ctrl: IMEM_TIMEOUT out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl: CNT_W must be positive");
    end

    hz_state_t   state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;
    logic        load_use;
    logic        lu_live;

    load_use_detect u_lud (
        .id_opcode  (id_opcode),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .load_use   (load_use)
    );

    // After one stall cycle the load has left EX, so only RUN acts on load_use.
    assign lu_live = load_use && (state_q == HZ_RUN);

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state_q <= HZ_RUN;
            fcnt_q  <= 3'd0;
            wcnt_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        wcnt_d  = 16'd0;
        err_d   = err_q;
        if (branch_taken) begin
            // A taken branch overrides everything, including an imem wait.
            fcnt_d  = FLUSH_LOAD;
            state_d = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;
        end else begin
            case (state_q)
                HZ_FLUSH: begin
                    if (fcnt_q <= 3'd1) begin
                        fcnt_d  = 3'd0;
                        state_d = HZ_RUN;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
                HZ_IMEM_WAIT: begin
                    if (imem_ready) begin
                        state_d = HZ_RUN;
                    end else begin
                        // Saturate so a long stall cannot wrap back under the limit.
                        wcnt_d = (wcnt_q == TIMEOUT_W) ? wcnt_q : wcnt_q + 16'd1;
                    end
                end
                default: begin
                    if (lu_live) begin
                        state_d = HZ_LU_STALL;
                    end else if (id_jump) begin
                        state_d = HZ_RUN;
                    end else if (!imem_ready) begin
                        state_d = HZ_IMEM_WAIT;
                        wcnt_d  = 16'd1;
                    end else begin
                        state_d = HZ_RUN;
                    end
                end
            endcase
        end
        if (wcnt_d == TIMEOUT_W) begin
            err_d = 1'b1;
        end
    end

    // FLUSH never looks at id_* so no combinational id path exists in that state.
    always_comb begin
        pc_enable  = 1'b1;
        enableIF   = 1'b1;
        resetIF    = 1'b0;
        flush_idex = 1'b0;
        if (reset) begin
            pc_enable  = 1'b0;
            enableIF   = 1'b0;
            resetIF    = 1'b1;
            flush_idex = 1'b1;
        end else if (state_q == HZ_FLUSH || branch_taken) begin
            resetIF    = 1'b1;
            flush_idex = 1'b1;
        end else if (state_q == HZ_IMEM_WAIT) begin
            pc_enable = imem_ready;
            enableIF  = imem_ready;
        end else if (lu_live) begin
            pc_enable  = 1'b0;
            enableIF   = 1'b0;
            flush_idex = 1'b1;
        end else if (id_jump) begin
            resetIF = 1'b1;
        end else if (!imem_ready) begin
            pc_enable = 1'b0;
            enableIF  = 1'b0;
        end
    end

    assign imem_err = err_q;
    assign state_o  = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_enable && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (resetIF && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int FC = 2;
    localparam int TO = 4;

    logic       reloj = 1'b0;
    logic       reset;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, branch_taken, id_jump, imem_ready;
    logic       pc_enable, enableIF, resetIF, flush_idex, imem_err;
    logic [1:0] state_o;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: phase 0 run, 1 load-use stall, 2 flushing, 3 waiting on imem.
    int m_phase, m_flush_left, m_low_run;
    bit m_err;
    bit e_pc, e_en, e_rst, e_fl;
    int m_stalls, m_flushes;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .IMEM_TIMEOUT(TO), .CNT_W(16)) dut (
        .reloj        (reloj),
        .reset        (reset),
        .id_opcode    (id_opcode),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .id_jump      (id_jump),
        .imem_ready   (imem_ready),
        .pc_enable    (pc_enable),
        .enableIF     (enableIF),
        .resetIF      (resetIF),
        .flush_idex   (flush_idex),
        .imem_err     (imem_err),
        .state_o      (state_o)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 reloj = ~reloj;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lu_now();
        bit reads_rt;
        reads_rt = (id_opcode == 6'h00) || (id_opcode == 6'h04) ||
                   (id_opcode == 6'h05) || (id_opcode == 6'h2b);
        return ex_memread && ex_rt != 0 && (ex_rt == id_rs || (ex_rt == id_rt && reads_rt));
    endfunction

    task automatic model_reset();
        m_phase = 0; m_flush_left = 0; m_low_run = 0; m_err = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    task automatic model_outputs();
        bit lu;
        lu = lu_now() && m_phase == 0;
        {e_pc, e_en, e_rst, e_fl} = 4'b1100;
        if (m_phase == 2 || branch_taken)   {e_pc, e_en, e_rst, e_fl} = 4'b1111;
        else if (m_phase == 3)              {e_pc, e_en, e_rst, e_fl} = imem_ready ? 4'b1100 : 4'b0000;
        else if (lu)                        {e_pc, e_en, e_rst, e_fl} = 4'b0001;
        else if (id_jump)                   {e_pc, e_en, e_rst, e_fl} = 4'b1110;
        else if (!imem_ready)               {e_pc, e_en, e_rst, e_fl} = 4'b0000;
    endtask

    task automatic model_advance();
        bit lu;
        lu = lu_now() && m_phase == 0;
        if (!e_pc)  m_stalls++;
        if (e_rst)  m_flushes++;
        if (branch_taken) begin
            m_flush_left = FC - 1;
            m_phase = (m_flush_left > 0) ? 2 : 0;
            m_low_run = 0;
        end else if (m_phase == 2) begin
            m_flush_left--;
            m_phase = (m_flush_left > 0) ? 2 : 0;
        end else if (m_phase == 3) begin
            if (imem_ready) begin m_phase = 0; m_low_run = 0; end
            else m_low_run++;
        end else if (lu) m_phase = 1;
        else if (id_jump) m_phase = 0;
        else if (!imem_ready) begin m_phase = 3; m_low_run = 1; end
        else m_phase = 0;
        if (m_low_run >= TO) m_err = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc_enable"},  pc_enable,  e_pc);
        chk({tag, ".enableIF"},   enableIF,   e_en);
        chk({tag, ".resetIF"},    resetIF,    e_rst);
        chk({tag, ".flush_idex"}, flush_idex, e_fl);
        chk({tag, ".state_o"},    state_o,    m_phase);
        chk({tag, ".imem_err"},   imem_err,   m_err);
`ifdef HAZ_PERF_CNT_EN
        chk({tag, ".stall_cnt"},  stall_cnt,  m_stalls);
        chk({tag, ".flush_cnt"},  flush_cnt,  m_flushes);
`endif
    endtask

    // Inputs are set just after a falling edge; check, clock, advance the model.
    task automatic cycle(input string tag);
        #1;
        model_outputs();
        check_all(tag);
        @(posedge reloj);
        model_advance();
        @(negedge reloj);
    endtask

    task automatic idle();
        id_opcode = 6'h00; id_rs = 5'd1; id_rt = 5'd2;
        ex_memread = 0; ex_rt = 5'd0;
        branch_taken = 0; id_jump = 0; imem_ready = 1;
    endtask

    initial begin
        idle();
        reset = 1;
        model_reset();
        repeat (2) @(posedge reloj);
        @(negedge reloj);
        chk("rst.pc_enable", pc_enable, 0);
        chk("rst.enableIF", enableIF, 0);
        chk("rst.resetIF", resetIF, 1);
        chk("rst.flush_idex", flush_idex, 1);
        chk("rst.state_o", state_o, 0);
        chk("rst.imem_err", imem_err, 0);
        reset = 0;
        cycle("run_idle");

        // LW $5 in EX, ADD $6,$5,$7 in IF/ID
        ex_memread = 1; ex_rt = 5'd5; id_opcode = 6'h00; id_rs = 5'd5; id_rt = 5'd7;
        cycle("lu_detect");
        idle();
        cycle("lu_stall_exit");
        cycle("lu_after");
        ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        cycle("lu_rt_zero");
        idle();

        branch_taken = 1;
        cycle("br_detect");
        branch_taken = 0;
        cycle("br_flush");
        cycle("br_back_run");

        branch_taken = 1; ex_memread = 1; ex_rt = 5'd9; id_rs = 5'd9;
        cycle("br_vs_lu");
        idle();
        cycle("br_vs_lu_flush");
        cycle("br_vs_lu_run");

        id_jump = 1;
        cycle("jump");
        idle();

        imem_ready = 0;
        repeat (3) cycle("imem_low3");
        imem_ready = 1;
        cycle("imem_low3_done");
        chk("imem_low3_err", imem_err, 0);

        imem_ready = 0;
        repeat (5) cycle("imem_low5");
        imem_ready = 1;
        cycle("imem_low5_done");
        cycle("imem_err_sticky");
        chk("imem_err_set", imem_err, 1);

        // Asynchronous reset landing between edges while in FLUSH.
        branch_taken = 1;
        cycle("pre_rst_br");
        branch_taken = 0;
        #2;
        chk("mid_flush_state", state_o, 2);
        reset = 1;
        #1;
        chk("async_rst.resetIF", resetIF, 1);
        chk("async_rst.pc_enable", pc_enable, 0);
        chk("async_rst.state_o", state_o, 0);
        @(negedge reloj);
        reset = 0;
        model_reset();
        #1;
        chk("post_rst.state_o", state_o, 0);
        chk("post_rst.imem_err", imem_err, 0);
        @(negedge reloj);

        for (int i = 0; i < 400; i++) begin
            id_opcode    = ($urandom_range(0, 3) == 0) ? 6'h23 : 6'($urandom_range(0, 6));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_memread   = ($urandom_range(0, 2) == 0);
            ex_rt        = 5'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 7) == 0);
            id_jump      = ($urandom_range(0, 9) == 0);
            imem_ready   = ($urandom_range(0, 5) != 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
